score_to_digits: RTL
====================

SCORE_TO_DIGITS -- requirements
Module: score_to_digits

Interface
REQ-001 Parameter BASE_STEP, default 10'd0: grid index of the top-left pixel of the hundreds glyph.
REQ-002 Parameter DIGIT_PITCH, default 10'd4: index distance between adjacent glyphs (3-pixel glyph plus 1-pixel gap).
REQ-003 Parameter BLANK_LEADING, default 1: when 1, leading zero digits are output as the blank code.
REQ-004 Parameter BLANK_CODE, default 10'd15: digit value that is outside 0..9, so the downstream bitmap stage draws nothing.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 start  input  1  request to convert score; sampled only in IDLE.
REQ-008 score  input  10  unsigned binary score.
REQ-009 busy  output  1  high while a conversion is in progress.
REQ-010 done  output  1  one-cycle pulse when new digit outputs become valid.
REQ-011 sat  output  1  registered flag; high when the last accepted score exceeded 999.
REQ-012 digit1 / digit2 / digit3  output  10 each  hundreds / tens / ones value (0..9 or BLANK_CODE), registered.
REQ-013 step1 / step2 / step3  output  10 each  constant glyph origins: BASE_STEP, BASE_STEP+DIGIT_PITCH, BASE_STEP+2*DIGIT_PITCH.

Function
REQ-014 FSM states: IDLE and CONV only.
REQ-015 IDLE: start=1 at edge E0 -> capture min(score, 999) into the shift register, clear the BCD accumulator and iteration counter, update sat, set busy=1, enter CONV.
REQ-016 Conversion uses shift-add-3 (double dabble): on each of edges E1..E10, add 3 to every BCD nibble >=5, then shift the combined {BCD, binary} register left by 1.
REQ-017 Iteration counter is 4 bits, counts 0..9, and is used only in CONV.
REQ-018 At edge E10: digit1..3 load the converted result, done=1, busy=0, state returns to IDLE.
REQ-019 At edge E11, done returns to 0.
REQ-020 Latency is fixed: done is high in the cycle after E10, regardless of score value.
REQ-021 start is ignored in CONV, including at edge E10; the earliest next accept is E11.
REQ-022 digit1..3 hold their previous values throughout CONV and change only at the done edge.
REQ-023 Blanking with BLANK_LEADING=1: digit1 = BLANK_CODE if hundreds = 0; digit2 = BLANK_CODE if hundreds = 0 and tens = 0; digit3 is never blanked.
REQ-024 With BLANK_LEADING=0, zero digits are output as 10'd0.
REQ-025 Saturation: score > 999 converts as 999 and sets sat=1; score <= 999 sets sat=0; sat updates only at the accepting edge E0.
REQ-026 step1..3 are constant; they are independent of state and reset.
REQ-027 Digit outputs are zero-extended to 10 bits; upper 6 bits are 0 except when BLANK_CODE is output.

Reset
REQ-028 reset=1 at an edge takes priority over all other inputs; reset in mid-CONV aborts the conversion with no done pulse.
REQ-029 Reset values: state=IDLE, busy=0, done=0, sat=0, digit3=0.
REQ-030 Reset value of digit1 and digit2: BLANK_CODE if BLANK_LEADING=1, else 0.
REQ-031 A start held high during reset is not accepted; the first accept is the first edge with reset=0 and start=1.

Verification
REQ-032 Reset, then start with score=123 -> busy high E0..E10; done high one cycle after E10; digit1=1, digit2=2, digit3=3; sat=0.
REQ-033 score=7, then score=0 (BLANK_LEADING=1) -> 15/15/7, then 15/15/0; with BLANK_LEADING=0 -> 0/0/7, then 0/0/0.
REQ-034 score=1023 -> 9/9/9 and sat=1; a following score=500 -> 5/0/0 and sat=0.
REQ-035 Accept score=45, then pulse start with score=999 at E5 and at E10 -> both ignored; result 15/4/5; exactly one done pulse.
REQ-036 Accept score=888, then assert reset at E6 -> no done pulse; outputs return to reset values; a new start with score=42 at the next edge after reset -> 15/4/2.
REQ-037 With defaults, step1=0, step2=4, step3=8 in every cycle, including during reset.

Source files
------------

// File: rtl/score_to_digits_if.sv
// score_to_digits_if - handshake and result bundle for score_to_digits.
//   start          : request to convert score (driven by master)
//   score[9:0]     : unsigned binary score (driven by master)
//   busy           : conversion in progress (driven by slave)
//   done           : one-cycle pulse, new digits valid (driven by slave)
//   sat            : last accepted score exceeded 999 (driven by slave)
//   digit1..3[9:0] : hundreds / tens / ones or blank code (driven by slave)
//   step1..3[9:0]  : constant glyph origins (driven by slave)
interface score_to_digits_if;
    logic       start;
    logic [9:0] score;
    logic       busy;
    logic       done;
    logic       sat;
    logic [9:0] digit1;
    logic [9:0] digit2;
    logic [9:0] digit3;
    logic [9:0] step1;
    logic [9:0] step2;
    logic [9:0] step3;

    modport master (
        output start, score,
        input  busy, done, sat, digit1, digit2, digit3, step1, step2, step3
    );

    modport slave (
        input  start, score,
        output busy, done, sat, digit1, digit2, digit3, step1, step2, step3
    );
endinterface

// File: rtl/score_to_digits.sv
// score_to_digits - converts a 10-bit binary score into three decimal digit
// codes for an on-screen glyph renderer, using a sequential double-dabble
// (shift-add-3) over a fixed 10 iterations.
//   clk   : single clock, rising edge
//   reset : synchronous, active-high
//   bus   : score_to_digits_if.slave (start/score in; busy/done/sat,
//           digit1..3 and constant glyph origins step1..3 out)
module score_to_digits #(
    parameter logic [9:0] BASE_STEP     = 10'd0,
    parameter logic [9:0] DIGIT_PITCH   = 10'd4,
    parameter bit         BLANK_LEADING = 1'b1,
    parameter logic [9:0] BLANK_CODE    = 10'd15
) (
    input  logic                clk,
    input  logic                reset,
    score_to_digits_if.slave    bus
);

    typedef enum logic {
        IDLE,
        CONV
    } state_t;

    localparam logic [9:0] MAX_SCORE = 10'd999;
    localparam logic [9:0] LEAD_RST  = BLANK_LEADING ? BLANK_CODE : 10'd0;

    state_t      r_state;
    logic [21:0] r_shift;   // {hundreds, tens, ones, binary}
    logic [3:0]  r_cnt;
    logic        r_busy;
    logic        r_done;
    logic        r_sat;
    logic [9:0]  r_digit1;
    logic [9:0]  r_digit2;
    logic [9:0]  r_digit3;

    logic        w_over;
    logic [9:0]  w_clamped;
    logic [21:0] w_adj;
    logic [21:0] w_next;
    logic [3:0]  w_hund;
    logic [3:0]  w_tens;
    logic [3:0]  w_ones;
    logic [9:0]  w_digit1;
    logic [9:0]  w_digit2;
    logic [9:0]  w_digit3;

    always_comb begin
        w_over    = (bus.score > MAX_SCORE);
        w_clamped = w_over ? MAX_SCORE : bus.score;

        // Add 3 to each BCD nibble >= 5 before the shift, so the shift
        // carries into the next decade correctly.
        w_adj = r_shift;
        for (int unsigned i = 0; i < 3; i++) begin
            if (r_shift[10 + 4*i +: 4] >= 4'd5) begin
                w_adj[10 + 4*i +: 4] = r_shift[10 + 4*i +: 4] + 4'd3;
            end
        end
        w_next = {w_adj[20:0], 1'b0};

        // Values of the BCD nibbles after the final shift.
        w_hund = w_next[21:18];
        w_tens = w_next[17:14];
        w_ones = w_next[13:10];

        w_digit3 = {6'd0, w_ones};
        w_digit2 = (BLANK_LEADING && (w_hund == 4'd0) && (w_tens == 4'd0))
                   ? BLANK_CODE : {6'd0, w_tens};
        w_digit1 = (BLANK_LEADING && (w_hund == 4'd0))
                   ? BLANK_CODE : {6'd0, w_hund};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_shift  <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_sat    <= 1'b0;
            r_digit1 <= LEAD_RST;
            r_digit2 <= LEAD_RST;
            r_digit3 <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_shift <= {12'd0, w_clamped};
                        r_cnt   <= '0;
                        r_sat   <= w_over;
                        r_busy  <= 1'b1;
                        r_state <= CONV;
                    end
                end
                CONV: begin
                    r_shift <= w_next;
                    if (r_cnt == 4'd9) begin
                        r_digit1 <= w_digit1;
                        r_digit2 <= w_digit2;
                        r_digit3 <= w_digit3;
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_cnt    <= '0;
                        r_state  <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.sat    = r_sat;
    assign bus.digit1 = r_digit1;
    assign bus.digit2 = r_digit2;
    assign bus.digit3 = r_digit3;

    assign bus.step1 = BASE_STEP;
    assign bus.step2 = BASE_STEP + DIGIT_PITCH;
    assign bus.step3 = BASE_STEP + DIGIT_PITCH + DIGIT_PITCH;

endmodule
